// File: rtl/lwc_rdi_source_if.sv
// lwc_rdi_source_if: seed input, reseed request and rdi output bundle of the randomness source
interface lwc_rdi_source_if #(
  parameter int RNDW = 64
);
  logic [31:0]     seed_data;
  logic            seed_valid;
  logic            seed_ready;
  logic            reseed_req;
  logic [RNDW-1:0] rdi_data;
  logic            rdi_valid;
  logic            rdi_ready;
  logic            health_fail;
  modport master (
    input  seed_data, seed_valid, reseed_req, rdi_ready,
    output seed_ready, rdi_data, rdi_valid, health_fail
  );
  modport slave (
    output seed_data, seed_valid, reseed_req, rdi_ready,
    input  seed_ready, rdi_data, rdi_valid, health_fail
  );
endinterface

// File: rtl/lwc_rdi_source.sv
// lwc_rdi_source: xorshift128 source packing 32-bit words into RNDW-bit rdi words, periodic reseed; RDI_HEALTH_EN adds a repeated-word check
module lwc_rdi_source #(
  parameter int RNDW       = 64,
  parameter int RESEED_CNT = 1024
) (
  input logic              clk,
  input logic              rst,
  lwc_rdi_source_if.master bus
);
  localparam int WORDS = RNDW / 32;
  localparam int KW    = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic {SEED, GEN} state_t;
  state_t          st, st_n;
  logic [31:0]     x, y, z, w, t, nw, rc;
  logic [1:0]      sc;
  logic [KW-1:0]   k;
  logic [RNDW-1:0] stg;
  logic            hs, last, step, load, trig, hf, bad;
`ifdef RDI_HEALTH_EN
  logic [31:0]     pw;
  logic            pv;
  // remember the previous generated word and latch a repeat as a sticky failure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pw <= '0;
      pv <= 1'b0;
      hf <= 1'b0;
    end else begin
      if (step) begin
        pw <= nw;
        pv <= 1'b1;
      end
      if (bad) hf <= 1'b1;
    end
  end
  assign bad = step && pv && nw == pw;
`else
  assign hf  = 1'b0;
  assign bad = 1'b0;
`endif
  // generator step, stall and reseed decisions
  always_comb begin
    t    = x ^ (x << 11);
    nw   = w ^ (w >> 19) ^ t ^ (t >> 8);
    hs   = bus.rdi_valid && bus.rdi_ready;
    last = k == KW'(WORDS - 1);
    step = st == GEN && !hf && !(last && bus.rdi_valid && !bus.rdi_ready);
    load = step && last && !bad;
    trig = st == GEN && (bus.reseed_req || bad || hf ||
           (RESEED_CNT != 0 && hs && rc + 32'd1 >= 32'(RESEED_CNT)));
    st_n = trig ? SEED : (st == SEED && bus.seed_valid && sc == 2'd3) ? GEN : st;
    bus.seed_ready  = st == SEED;
    bus.health_fail = hf;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= SEED;
    else st <= st_n;
  end
  // seed absorption, generator state, packing and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {x, y, z, w} <= '0;
      sc            <= '0;
      k             <= '0;
      stg           <= '0;
      rc            <= '0;
      bus.rdi_data  <= '0;
      bus.rdi_valid <= 1'b0;
    end else begin
      if (st == SEED && bus.seed_valid) begin
        {x, y, z, w} <= {y, z, w, bus.seed_data};
        if (sc == 2'd3 && {y, z, w, bus.seed_data} == '0) w <= 32'h1;
        sc <= sc + 2'd1;
      end else if (step) begin
        x <= y;
        y <= z;
        z <= w;
        w <= nw;
      end
      if (trig) begin
        k   <= '0;
        stg <= '0;
      end else if (step) begin
        k <= last ? '0 : k + KW'(1);
        if (!last) stg <= (stg << 32) | RNDW'(nw);
      end
      if (load) bus.rdi_data <= (stg << 32) | RNDW'(nw);
      bus.rdi_valid <= bad ? 1'b0 : load ? 1'b1 : hs ? 1'b0 : bus.rdi_valid;
      rc <= trig ? '0 : rc + (hs ? 32'd1 : 32'd0);
    end
  end
endmodule
